// File: rtl/plab5_mcore_mem_acc_ctrl_pkg.sv
//==============================================================================
// plab5_mcore_mem_acc_ctrl_pkg : shared message/tag layout helpers
// Revision: 1.0
//==============================================================================
`default_nettype none

package plab5_mcore_mem_acc_ctrl_pkg;

  localparam int c_MSG_TYPE_NBITS = 3;

  typedef enum logic [c_MSG_TYPE_NBITS-1:0] {
    MSG_TYPE_READ  = 3'd0,
    MSG_TYPE_WRITE = 3'd1,
    MSG_TYPE_INIT  = 3'd2
  } mem_msg_type_e;

  // Request control = {type, opaque, addr, len}; response control = {type, opaque, len}.
  function automatic int calc_len_nbits(input int data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  function automatic int calc_req_cnbits(input int opaque_nbits, input int addr_nbits,
                                         input int data_nbits);
    return c_MSG_TYPE_NBITS + opaque_nbits + addr_nbits + calc_len_nbits(data_nbits);
  endfunction

  function automatic int calc_resp_cnbits(input int opaque_nbits, input int data_nbits);
    return c_MSG_TYPE_NBITS + opaque_nbits + calc_len_nbits(data_nbits);
  endfunction

  // Tag entry = {allow, req_level, mem_level, type, opaque, len}; low bits form a response control.
  function automatic int calc_tag_nbits(input int sec_nbits, input int opaque_nbits,
                                        input int data_nbits);
    return 1 + 2 * sec_nbits + calc_resp_cnbits(opaque_nbits, data_nbits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/plab5_mcore_mem_acc_ctrl_tagq.sv
//==============================================================================
// plab5_mcore_mem_acc_ctrl_tagq : synchronous tag FIFO with count and flags
// Revision: 1.0
//==============================================================================
`default_nettype none

module plab5_mcore_mem_acc_ctrl_tagq #(
  parameter int p_width = 8,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [p_width-1:0] i_data,
  input  logic               i_pop,
  output logic [p_width-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int c_PTR_NBITS = $clog2(p_depth);
  localparam int c_CNT_NBITS = $clog2(p_depth + 1);
  localparam logic [c_CNT_NBITS-1:0] c_DEPTH = c_CNT_NBITS'(p_depth);

  logic [p_width-1:0]     r_mem [p_depth];
  logic [c_PTR_NBITS-1:0] r_wr_ptr;
  logic [c_PTR_NBITS-1:0] r_rd_ptr;
  logic [c_CNT_NBITS-1:0] r_count;
  logic                   w_push;
  logic                   w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/plab5_mcore_mem_acc_ctrl.sv
//==============================================================================
// plab5_mcore_mem_acc_ctrl : security-level gate between network and memory
// Revision: 1.0
//==============================================================================
`default_nettype none

module plab5_mcore_mem_acc_ctrl
  import plab5_mcore_mem_acc_ctrl_pkg::*;
#(
  parameter int p_opaque_nbits    = 8,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 32,
  parameter int p_sec_nbits       = 2,
  parameter int p_max_outstanding = 4,
  parameter int p_cnt_nbits       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_sec_nbits-1:0] req_sec_level,
  input  logic [p_sec_nbits-1:0] mem_sec_level,

  input  logic [calc_req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] net_req_control,
  input  logic [p_data_nbits-1:0] net_req_data,
  input  logic                    net_req_val,
  output logic                    net_req_rdy,

  output logic [calc_req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] mem_req_control,
  output logic [p_data_nbits-1:0] mem_req_data,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,

  input  logic [calc_resp_cnbits(p_opaque_nbits, p_data_nbits)-1:0] mem_resp_control,
  input  logic [p_data_nbits-1:0] mem_resp_data,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,

  output logic [calc_resp_cnbits(p_opaque_nbits, p_data_nbits)-1:0] net_resp_control,
  output logic [p_data_nbits-1:0] net_resp_data,
  output logic                    net_resp_val,
  input  logic                    net_resp_rdy,

  output logic [p_sec_nbits-1:0]  resp_sec_level,
  output logic                    net_resp_denied,
  output logic                    violation,
  output logic [p_cnt_nbits-1:0]  violation_count
);

  localparam int c_LEN_NBITS     = calc_len_nbits(p_data_nbits);
  localparam int c_REQ_CNBITS    = calc_req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);
  localparam int c_RESP_CNBITS   = calc_resp_cnbits(p_opaque_nbits, p_data_nbits);
  localparam int c_TAG_NBITS     = calc_tag_nbits(p_sec_nbits, p_opaque_nbits, p_data_nbits);
  localparam int c_REQ_OPQ_MSB   = c_REQ_CNBITS - c_MSG_TYPE_NBITS - 1;

  logic                         w_allow;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_empty;
  logic [c_TAG_NBITS-1:0]       w_tag_in;
  logic [c_TAG_NBITS-1:0]       w_head;
  logic                         w_head_allow;
  logic [p_sec_nbits-1:0]       w_head_req_sec;
  logic [p_sec_nbits-1:0]       w_head_mem_sec;
  logic [c_RESP_CNBITS-1:0]     w_head_resp_ctl;
  logic                         r_violation;
  logic [p_cnt_nbits-1:0]       r_vcount;

  assign w_allow = (req_sec_level >= mem_sec_level);

  assign w_tag_in = {w_allow, req_sec_level, mem_sec_level,
                     net_req_control[c_REQ_CNBITS-1 -: c_MSG_TYPE_NBITS],
                     net_req_control[c_REQ_OPQ_MSB -: p_opaque_nbits],
                     net_req_control[c_LEN_NBITS-1:0]};

  assign w_head_allow    = w_head[c_TAG_NBITS-1];
  assign w_head_req_sec  = w_head[c_TAG_NBITS-2 -: p_sec_nbits];
  assign w_head_mem_sec  = w_head[c_TAG_NBITS-2-p_sec_nbits -: p_sec_nbits];
  assign w_head_resp_ctl = w_head[c_RESP_CNBITS-1:0];

  // Denied requests never wait on the memory's ready; only queue space gates them.
  always_comb begin
    mem_req_control = net_req_control;
    mem_req_data    = net_req_data;
    mem_req_val     = net_req_val && w_allow && !w_full;
    net_req_rdy     = !w_full && (w_allow ? mem_req_rdy : 1'b1);
    w_push          = net_req_val && net_req_rdy;
  end

  always_comb begin
    net_resp_control = '0;
    net_resp_data    = '0;
    net_resp_val     = 1'b0;
    mem_resp_rdy     = 1'b0;
    resp_sec_level   = '0;
    net_resp_denied  = 1'b0;
    w_pop            = 1'b0;
    if (!w_empty) begin
      if (w_head_allow) begin
        net_resp_control = mem_resp_control;
        net_resp_data    = mem_resp_data;
        net_resp_val     = mem_resp_val;
        mem_resp_rdy     = net_resp_rdy;
        resp_sec_level   = w_head_mem_sec;
        w_pop            = mem_resp_val && net_resp_rdy;
      end else begin
        net_resp_control = w_head_resp_ctl;
        net_resp_val     = 1'b1;
        resp_sec_level   = w_head_req_sec;
        net_resp_denied  = 1'b1;
        w_pop            = net_resp_rdy;
      end
    end
  end

  plab5_mcore_mem_acc_ctrl_tagq #(
    .p_width (c_TAG_NBITS),
    .p_depth (p_max_outstanding)
  ) u_tagq (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (w_tag_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_violation <= 1'b0;
      r_vcount    <= '0;
    end else begin
      r_violation <= w_push && !w_allow;
      if (w_push && !w_allow && (r_vcount != '1)) begin
        r_vcount <= r_vcount + 1'b1;
      end
    end
  end

  assign violation       = r_violation;
  assign violation_count = r_vcount;

endmodule

`default_nettype wire

// File: tb/tb_plab5_mcore_mem_acc_ctrl.sv
//==============================================================================
// tb_plab5_mcore_mem_acc_ctrl : randomized bench against an in-order queue model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_plab5_mcore_mem_acc_ctrl;

  localparam int OPQ  = 8;
  localparam int ADDR = 32;
  localparam int DATA = 32;
  localparam int SEC  = 2;
  localparam int MAXO = 4;
  localparam int CNT  = 4;
  localparam int RQCN = 3 + OPQ + ADDR + 2;
  localparam int RSCN = 3 + OPQ + 2;
  localparam int CMAX = (1 << CNT) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [SEC-1:0]  req_sec_level, mem_sec_level;
  logic [RQCN-1:0] net_req_control, mem_req_control;
  logic [DATA-1:0] net_req_data, mem_req_data;
  logic            net_req_val, net_req_rdy, mem_req_val, mem_req_rdy;
  logic [RSCN-1:0] mem_resp_control, net_resp_control;
  logic [DATA-1:0] mem_resp_data, net_resp_data;
  logic            mem_resp_val, mem_resp_rdy, net_resp_val, net_resp_rdy;
  logic [SEC-1:0]  resp_sec_level;
  logic            net_resp_denied, violation;
  logic [CNT-1:0]  violation_count;

  plab5_mcore_mem_acc_ctrl #(
    .p_opaque_nbits(OPQ), .p_addr_nbits(ADDR), .p_data_nbits(DATA),
    .p_sec_nbits(SEC), .p_max_outstanding(MAXO), .p_cnt_nbits(CNT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_sec_level(req_sec_level), .mem_sec_level(mem_sec_level),
    .net_req_control(net_req_control), .net_req_data(net_req_data),
    .net_req_val(net_req_val), .net_req_rdy(net_req_rdy),
    .mem_req_control(mem_req_control), .mem_req_data(mem_req_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_control(mem_resp_control), .mem_resp_data(mem_resp_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .net_resp_control(net_resp_control), .net_resp_data(net_resp_data),
    .net_resp_val(net_resp_val), .net_resp_rdy(net_resp_rdy),
    .resp_sec_level(resp_sec_level), .net_resp_denied(net_resp_denied),
    .violation(violation), .violation_count(violation_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RSCN-1:0] ctl;
    logic [DATA-1:0] data;
    logic [SEC-1:0]  sec;
    logic            denied;
  } exp_t;

  typedef struct {
    logic [RSCN-1:0] ctl;
    logic [DATA-1:0] data;
  } mresp_t;

  exp_t   exp_q[$];
  mresp_t mem_q[$];
  int     exp_cnt;
  logic   exp_viol;
  int     n_vec;
  int     n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: responses leave in accept order; a request is either
  // answered by memory (level >= memory level) or by a zero-data denial.
  always @(negedge clk) begin : model
    logic e_full, e_allow, e_nrr, e_mrv, e_nsv, e_mrr, nv;
    exp_t   e;
    mresp_t m;
    if (!reset) begin
      exp_q.delete();
      mem_q.delete();
      exp_cnt  = 0;
      exp_viol = 1'b0;
    end else begin
      e_full  = (exp_q.size() >= MAXO);
      e_allow = (int'(req_sec_level) >= int'(mem_sec_level));
      e_nrr   = !e_full && (e_allow ? mem_req_rdy : 1'b1);
      e_mrv   = net_req_val && e_allow && !e_full;
      if (exp_q.size() == 0) begin
        e_nsv = 1'b0; e_mrr = 1'b0;
      end else if (exp_q[0].denied) begin
        e_nsv = 1'b1; e_mrr = 1'b0;
      end else begin
        e_nsv = mem_resp_val; e_mrr = net_resp_rdy;
      end
      check_eq("net_req_rdy", 64'(net_req_rdy), 64'(e_nrr));
      check_eq("mem_req_val", 64'(mem_req_val), 64'(e_mrv));
      check_eq("net_resp_val", 64'(net_resp_val), 64'(e_nsv));
      check_eq("mem_resp_rdy", 64'(mem_resp_rdy), 64'(e_mrr));
      check_eq("violation", 64'(violation), 64'(exp_viol));
      check_eq("violation_count", 64'(violation_count), 64'(exp_cnt));
      if (e_mrv) begin
        check_eq("mem_req_control", 64'(mem_req_control), 64'(net_req_control));
        check_eq("mem_req_data", 64'(mem_req_data), 64'(net_req_data));
      end
      if (e_nsv && net_resp_val) begin
        check_eq("net_resp_control", 64'(net_resp_control), 64'(exp_q[0].ctl));
        check_eq("net_resp_data", 64'(net_resp_data), 64'(exp_q[0].data));
        check_eq("resp_sec_level", 64'(resp_sec_level), 64'(exp_q[0].sec));
        check_eq("net_resp_denied", 64'(net_resp_denied), 64'(exp_q[0].denied));
      end
      if (e_nsv && net_resp_rdy) void'(exp_q.pop_front());
      if (mem_resp_val && e_mrr && mem_q.size() != 0) void'(mem_q.pop_front());
      nv = 1'b0;
      if (net_req_val && e_nrr) begin
        e.ctl = {net_req_control[RQCN-1 -: 3+OPQ], net_req_control[1:0]};
        if (e_allow) begin
          m.ctl  = e.ctl;
          m.data = (net_req_control[RQCN-1 -: 3] == 3'd0)
                   ? (net_req_control[ADDR+1:2] ^ 32'hCAFEF00D) : (net_req_data ^ 32'h1234_5678);
          mem_q.push_back(m);
          e.data   = m.data;
          e.sec    = mem_sec_level;
          e.denied = 1'b0;
        end else begin
          e.data   = '0;
          e.sec    = req_sec_level;
          e.denied = 1'b1;
          nv       = 1'b1;
          if (exp_cnt < CMAX) exp_cnt++;
        end
        exp_q.push_back(e);
      end
      exp_viol = nv;
    end
  end

  // Phase table: cycles, %req, %mem answers, %net_resp_rdy, %mem_req_rdy, mem level (4 = random), reset.
  int ph_n   [6] = '{40, 40, 30, 120, 30, 120};
  int ph_req [6] = '{70, 80, 60,  80,  0,  60};
  int ph_resp[6] = '{60,  0, 60,  50, 100, 50};
  int ph_nrdy[6] = '{80,100, 80,  50, 100, 70};
  int ph_mrdy[6] = '{80,100, 90,  70, 100, 70};
  int ph_mlvl[6] = '{ 1,  0,  4,   3,  0,   4};
  bit ph_rst [6] = '{ 0,  0,  1,   0,  0,   0};

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  initial begin
    n_vec = 0; n_err = 0; exp_cnt = 0; exp_viol = 1'b0;
    reset = 1'b0;
    req_sec_level = '0; mem_sec_level = '0;
    net_req_control = '0; net_req_data = '0; net_req_val = 1'b0;
    mem_req_rdy = 1'b0; net_resp_rdy = 1'b0;
    mem_resp_control = '0; mem_resp_data = '0; mem_resp_val = 1'b0;
    repeat (3) @(posedge clk);
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < ph_n[ph]; c++) begin
        @(posedge clk);
        #1;
        reset           = !(ph_rst[ph] && c < 2);
        mem_sec_level   = (ph_mlvl[ph] == 4) ? SEC'($urandom_range(3)) : SEC'(ph_mlvl[ph]);
        req_sec_level   = SEC'($urandom_range(3));
        net_req_val     = reset && pct(ph_req[ph]);
        net_req_control = {3'($urandom_range(1)), 8'($urandom), 32'($urandom), 2'($urandom)};
        net_req_data    = $urandom;
        mem_req_rdy     = pct(ph_mrdy[ph]);
        net_resp_rdy    = pct(ph_nrdy[ph]);
        if (mem_q.size() != 0) begin
          mem_resp_val     = reset && pct(ph_resp[ph]);
          mem_resp_control = mem_q[0].ctl;
          mem_resp_data    = mem_q[0].data;
        end else begin
          mem_resp_val     = reset && (exp_q.size() == 0) && pct(20);
          mem_resp_control = RSCN'($urandom);
          mem_resp_data    = $urandom;
        end
      end
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
